// File: rtl/aes_rx_unpacker.sv
// Receive-side unpacker: reframes the per-beat cipher stream into payload beats with
// sop/last markers and byte enables, and checks beat counts against the header length.
module aes_rx_unpacker #(
  parameter int unsigned HDR_BYTES = 14,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_cp_ready,
  input  logic             i_last,
  input  logic [0:127]     i_cipher_text,
  input  logic [288:0]     i_bypass_text,
  output logic             o_valid,
  output logic             o_sop,
  output logic             o_last,
  output logic [0:127]     o_data,
  output logic [15:0]      o_keep,
  output logic [15:0]      o_len,
  output logic             o_err,
  output logic [CNT_W-1:0] o_pkt_cnt,
  output logic [CNT_W-1:0] o_err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BODY,
    S_DROP
  } state_t;

  state_t            r_state;
  logic [11:0]       r_cnt;
  logic [12:0]       r_nbeats;
  logic [15:0]       r_last_keep;
  logic              r_valid;
  logic              r_sop;
  logic              r_last;
  logic              r_err;
  logic [0:127]      r_data;
  logic [15:0]       r_keep;
  logic [15:0]       r_len;
  logic [CNT_W-1:0]  r_pkt_cnt;
  logic [CNT_W-1:0]  r_err_cnt;

  logic [15:0]       w_len;
  logic              w_bad;
  logic [15:0]       w_p;
  logic [12:0]       w_nbeats;
  logic [15:0]       w_keep;
  logic [11:0]       w_cnt_inc;
  logic              w_reach;
  logic              w_unused;

  // Only the length field of the first beat's bypass word matters here.
  assign w_len     = i_bypass_text[48:33];
  assign w_unused  = ^{i_bypass_text[288:49], i_bypass_text[32:0]};
  assign w_bad     = (w_len < 16'(HDR_BYTES));
  assign w_p       = w_len - 16'(HDR_BYTES);
  assign w_cnt_inc = r_cnt + 12'd1;
  assign w_reach   = ({1'b0, w_cnt_inc} == r_nbeats);

  always_comb begin
    w_nbeats = 13'd1;
    if (w_p != '0) begin
      w_nbeats = {1'b0, w_p[15:4]} + {12'd0, |w_p[3:0]};
    end
  end

  always_comb begin
    w_keep = '1;
    if (w_p == '0) begin
      w_keep = '0;
    end else if (w_p[3:0] != 4'd0) begin
      w_keep = ~(16'hFFFF >> w_p[3:0]);
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_nbeats    <= '0;
      r_last_keep <= '0;
      r_valid     <= 1'b0;
      r_sop       <= 1'b0;
      r_last      <= 1'b0;
      r_err       <= 1'b0;
      r_data      <= '0;
      r_keep      <= '0;
      r_len       <= '0;
      r_pkt_cnt   <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      if (i_cp_ready) begin
        case (r_state)
          S_IDLE: begin
            r_cnt <= 12'd1;
            if (w_bad) begin
              if (i_last) begin
                r_err     <= 1'b1;
                r_err_cnt <= sat_inc(r_err_cnt);
              end else begin
                r_state <= S_DROP;
              end
            end else begin
              r_valid     <= 1'b1;
              r_sop       <= 1'b1;
              r_len       <= w_p;
              r_data      <= i_cipher_text;
              r_nbeats    <= w_nbeats;
              r_last_keep <= w_keep;
              if (i_last && (w_nbeats != 13'd1)) begin
                r_last    <= 1'b1;
                r_err     <= 1'b1;
                r_keep    <= '1;
                r_pkt_cnt <= sat_inc(r_pkt_cnt);
                r_err_cnt <= sat_inc(r_err_cnt);
              end else if (i_last || (w_nbeats == 13'd1)) begin
                // Single-beat frame; any extra beats are an overrun flagged at their tail.
                r_last    <= 1'b1;
                r_keep    <= w_keep;
                r_pkt_cnt <= sat_inc(r_pkt_cnt);
                if (!i_last) begin
                  r_state <= S_DROP;
                end
              end else begin
                r_keep  <= '1;
                r_state <= S_BODY;
              end
            end
          end
          S_BODY: begin
            r_cnt   <= w_cnt_inc;
            r_valid <= 1'b1;
            r_data  <= i_cipher_text;
            if (w_reach) begin
              r_last    <= 1'b1;
              r_keep    <= r_last_keep;
              r_pkt_cnt <= sat_inc(r_pkt_cnt);
              r_state   <= i_last ? S_IDLE : S_DROP;
            end else if (i_last) begin
              r_last    <= 1'b1;
              r_err     <= 1'b1;
              r_keep    <= '1;
              r_pkt_cnt <= sat_inc(r_pkt_cnt);
              r_err_cnt <= sat_inc(r_err_cnt);
              r_state   <= S_IDLE;
            end else begin
              r_keep <= '1;
            end
          end
          S_DROP: begin
            r_cnt <= w_cnt_inc;
            if (i_last) begin
              r_err     <= 1'b1;
              r_err_cnt <= sat_inc(r_err_cnt);
              r_state   <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_sop     = r_sop;
  assign o_last    = r_last;
  assign o_data    = r_data;
  assign o_keep    = r_keep;
  assign o_len     = r_len;
  assign o_err     = r_err;
  assign o_pkt_cnt = r_pkt_cnt;
  assign o_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_aes_rx_unpacker.sv
// Directed bench for aes_rx_unpacker: a frame-level model predicts every output cycle,
// and one negedge process compares the DUT against those predictions.
module tb_aes_rx_unpacker;

  logic           clk = 1'b0;
  logic           reset;
  logic           i_cp_ready;
  logic           i_last;
  logic [0:127]   i_cipher_text;
  logic [288:0]   i_bypass_text;
  logic           o_valid, o_sop, o_last, o_err;
  logic [0:127]   o_data;
  logic [15:0]    o_keep, o_len;
  logic [15:0]    o_pkt_cnt, o_err_cnt;

  aes_rx_unpacker #(.HDR_BYTES(14), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .i_cp_ready(i_cp_ready), .i_last(i_last),
    .i_cipher_text(i_cipher_text), .i_bypass_text(i_bypass_text),
    .o_valid(o_valid), .o_sop(o_sop), .o_last(o_last), .o_data(o_data),
    .o_keep(o_keep), .o_len(o_len), .o_err(o_err),
    .o_pkt_cnt(o_pkt_cnt), .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         valid;
    logic         sop;
    logic         last;
    logic         err;
    logic [127:0] data;
    logic [15:0]  keep;
    logic [15:0]  len;
  } exp_t;

  exp_t exp_q[int];
  bit   rst_exp[int];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   m_pkt = 0;
  int   m_err = 0;
  bit   run = 1'b1;
  logic [15:0] last_keep_seen = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, expv);
    end
  endtask

  // Last-beat byte enables: one bit per valid byte, byte 0 in bit 15.
  function automatic logic [15:0] model_keep(input int p);
    logic [15:0] k;
    int r;
    if (p == 0) return 16'h0000;
    r = p % 16;
    if (r == 0) return 16'hFFFF;
    k = '0;
    for (int j = 0; j < r; j++) k[15-j] = 1'b1;
    return k;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (run && cyc > 0) begin
      if (rst_exp.exists(cyc)) begin
        m_pkt = 0;
        m_err = 0;
        chk("rst_valid", 128'(o_valid), 128'(0));
        chk("rst_sop",   128'(o_sop),   128'(0));
        chk("rst_last",  128'(o_last),  128'(0));
        chk("rst_err",   128'(o_err),   128'(0));
        chk("rst_data",  128'(o_data),  128'(0));
        chk("rst_keep",  128'(o_keep),  128'(0));
        chk("rst_len",   128'(o_len),   128'(0));
        chk("rst_pkt_cnt", 128'(o_pkt_cnt), 128'(0));
        chk("rst_err_cnt", 128'(o_err_cnt), 128'(0));
      end else begin
        e = exp_q.exists(cyc) ? exp_q[cyc] : '0;
        chk("valid", 128'(o_valid), 128'(e.valid));
        chk("sop",   128'(o_sop),   128'(e.sop));
        chk("last",  128'(o_last),  128'(e.last));
        chk("err",   128'(o_err),   128'(e.err));
        if (e.valid) begin
          chk("data", 128'(o_data), e.data);
          chk("keep", 128'(o_keep), 128'(e.keep));
        end
        if (e.sop) chk("len", 128'(o_len), 128'(e.len));
        if (e.last) m_pkt++;
        if (e.err) m_err++;
        chk("pkt_cnt", 128'(o_pkt_cnt), 128'(m_pkt));
        chk("err_cnt", 128'(o_err_cnt), 128'(m_err));
        if (o_valid && o_last) last_keep_seen = o_keep;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      i_cp_ready    = 1'b0;
      i_last        = 1'($urandom);
      i_cipher_text = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    i_cp_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      rst_exp[cyc+1] = 1'b1;
      step();
    end
    reset = 1'b0;
  endtask

  // Frame of M beats with length field L; abort>0 sends only that many beats, no i_last.
  task automatic send_frame(input int L, input int M, input bit gap, input int abort);
    int P, N, E, nd;
    bit bad;
    exp_t e;
    logic [127:0] cd;
    logic [288:0] bp;
    bad = (L < 14);
    P   = L - 14;
    N   = (bad || P == 0) ? 1 : (P + 15) / 16;
    E   = (M < N) ? M : N;
    nd  = (abort > 0) ? abort : M;
    for (int i = 1; i <= nd; i++) begin
      cd = {$urandom, $urandom, $urandom, $urandom};
      bp = '0;
      for (int w = 0; w < 10; w++) bp = {bp[256:0], 32'($urandom)};
      if (i == 1) bp[48:33] = 16'(L);
      i_cp_ready    = 1'b1;
      i_last        = (i == M);
      i_cipher_text = cd;
      i_bypass_text = bp;
      e = '0;
      if (!bad && i <= N) begin
        e.valid = 1'b1;
        e.sop   = (i == 1);
        e.last  = (i == E);
        e.err   = (i == E) && (M < N);
        e.data  = cd;
        e.keep  = ((i == E) && (M >= N)) ? model_keep(P) : 16'hFFFF;
        e.len   = (i == 1) ? 16'(P) : 16'h0;
      end
      if (i == M && (bad || M > N)) e.err = 1'b1;
      if (e.valid || e.err) exp_q[cyc+1] = e;
      step();
      if (gap) idle(1);
    end
    i_cp_ready = 1'b0;
    i_last     = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    i_cp_ready = 1'b0;
    i_last = 1'b0;
    i_cipher_text = '0;
    i_bypass_text = '0;
    do_reset(2);
    idle(1);

    send_frame(62, 3, 1'b0, 0);
    idle(2);
    chk("lit_pkt_after_normal", 128'(o_pkt_cnt), 128'(1));
    chk("lit_err_after_normal", 128'(o_err_cnt), 128'(0));

    send_frame(33, 2, 1'b0, 0);
    send_frame(15, 1, 1'b0, 0);
    idle(2);
    chk("lit_keep_p1", 128'(last_keep_seen), 128'(16'h8000));
    chk("lit_pkt_after_trim", 128'(o_pkt_cnt), 128'(3));

    send_frame(78, 2, 1'b0, 0);
    idle(2);
    chk("lit_keep_underrun", 128'(last_keep_seen), 128'(16'hFFFF));
    chk("lit_err_after_underrun", 128'(o_err_cnt), 128'(1));

    send_frame(30, 3, 1'b0, 0);
    send_frame(10, 1, 1'b0, 0);
    send_frame(5, 3, 1'b0, 0);
    idle(2);
    chk("lit_err_after_overrun", 128'(o_err_cnt), 128'(4));
    chk("lit_pkt_after_overrun", 128'(o_pkt_cnt), 128'(5));

    send_frame(17, 1, 1'b0, 0);
    idle(1);
    chk("lit_keep_p3", 128'(last_keep_seen), 128'(16'hE000));
    send_frame(14, 1, 1'b0, 0);
    idle(1);
    chk("lit_keep_p0", 128'(last_keep_seen), 128'(16'h0000));

    send_frame(78, 4, 1'b1, 0);
    send_frame(33, 2, 1'b1, 0);
    idle(2);
    chk("lit_pkt_after_gaps", 128'(o_pkt_cnt), 128'(9));

    send_frame(78, 1000, 1'b0, 2);
    do_reset(1);
    send_frame(46, 2, 1'b0, 0);
    idle(3);
    chk("lit_pkt_after_reset", 128'(o_pkt_cnt), 128'(1));
    chk("lit_err_after_reset", 128'(o_err_cnt), 128'(0));

    run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
